// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch, decode and REPEAT expansion stage.
// Optional INST_FETCH_PREFETCH_EN overlaps the next fetch with the last handshake.
module inst_fetch_unit #(
  parameter int                   INST_W    = 32,
  parameter int                   OPCODE_W  = 4,
  parameter int                   ADDR_W    = 8,
  parameter int                   COUNT_W   = 16,
  parameter logic [OPCODE_W-1:0]  OP_HALT   = 4'h0,
  parameter logic [OPCODE_W-1:0]  OP_REPEAT = 4'hF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          start_addr,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [INST_W-1:0]          mem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPCODE_W-1:0]        out_opcode,
  output logic [INST_W-OPCODE_W-1:0] out_operand,
  output logic                       out_first,
  output logic [COUNT_W-1:0]         out_iter,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  typedef enum logic [2:0] {
    IDLE, REQ, LATCH, ISSUE, REPLAY, HALTED
  } state_t;

  state_t                     state;
  logic [ADDR_W-1:0]          pc;
  logic [ADDR_W-1:0]          pc_inc;
  logic [COUNT_W-1:0]         rep_n;
  logic                       have_prev;
  logic                       req;
  logic                       hs;
  logic                       last_hs;
  logic                       fetch_fire;
  logic [OPCODE_W-1:0]        d_op;
  logic [INST_W-OPCODE_W-1:0] d_operand;
  logic [COUNT_W-1:0]         d_count;
  logic                       is_halt;
  logic                       is_rep;
  logic                       bad_rep;
  logic                       skip_rep;
  logic                       run_rep;

  assign pc_inc    = pc + ADDR_W'(1);
  assign d_op      = mem_data[INST_W-1 -: OPCODE_W];
  assign d_operand = mem_data[INST_W-OPCODE_W-1:0];
  assign d_count   = mem_data[COUNT_W-1:0];

  assign is_halt  = (d_op == OP_HALT);
  assign is_rep   = (d_op == OP_REPEAT);
  assign bad_rep  = is_rep && !have_prev;
  assign skip_rep = is_rep && have_prev && (d_count == '0);
  assign run_rep  = is_rep && have_prev && (d_count != '0);

  assign hs      = out_valid && out_ready;
  assign last_hs = hs && ((state == ISSUE) ||
                          (state == REPLAY && out_iter == rep_n));

`ifdef INST_FETCH_PREFETCH_EN
  assign fetch_fire = last_hs;
`else
  assign fetch_fire = 1'b0;
`endif

  assign mem_rd_en = req || fetch_fire;
  assign mem_addr  = fetch_fire ? pc_inc : pc;

  // Sequencer: fetch, decode, issue and replay with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      rep_n       <= '0;
      have_prev   <= 1'b0;
      req         <= 1'b0;
      out_valid   <= 1'b0;
      out_opcode  <= '0;
      out_operand <= '0;
      out_first   <= 1'b0;
      out_iter    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      req <= 1'b0;
      unique case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc        <= start_addr;
            done      <= 1'b0;
            error     <= 1'b0;
            have_prev <= 1'b0;
            busy      <= 1'b1;
            req       <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: state <= LATCH;
        LATCH: begin
          unique case (1'b1)
            is_halt: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= HALTED;
            end
            bad_rep: begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= HALTED;
            end
            skip_rep: begin
              pc    <= pc_inc;
              req   <= 1'b1;
              state <= REQ;
            end
            run_rep: begin
              rep_n     <= d_count;
              out_iter  <= COUNT_W'(1);
              out_first <= 1'b0;
              out_valid <= 1'b1;
              state     <= REPLAY;
            end
            default: begin
              out_opcode  <= d_op;
              out_operand <= d_operand;
              out_first   <= 1'b1;
              out_iter    <= '0;
              have_prev   <= 1'b1;
              out_valid   <= 1'b1;
              state       <= ISSUE;
            end
          endcase
        end
        ISSUE, REPLAY: begin
          if (last_hs) begin
            pc        <= pc_inc;
            out_valid <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
            state     <= LATCH;
`else
            req       <= 1'b1;
            state     <= REQ;
`endif
          end else if (hs) begin
            out_iter <= out_iter + COUNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: scoreboard bench for inst_fetch_unit.
// Tests queue expected beats; a handshake monitor pops and compares them.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

`ifdef INST_FETCH_PREFETCH_EN
  localparam int SPAN = 8;
`else
  localparam int SPAN = 12;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  start_addr = '0;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        out_valid;
  logic [3:0]  out_opcode;
  logic [27:0] out_operand;
  logic        out_first;
  logic [15:0] out_iter;
  logic        busy;
  logic        done;
  logic        error;

  logic [31:0] mem [0:255];
  logic [48:0] sb [$];
  int          hs_t [$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  logic [48:0] mon_got;
  logic [48:0] mon_exp;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .start_addr(start_addr),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_opcode(out_opcode),
    .out_operand(out_operand),
    .out_first(out_first),
    .out_iter(out_iter),
    .busy(busy),
    .done(done),
    .error(error)
  );

  // Synchronous instruction RAM model with read counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) begin
      mem_data <= mem[mem_addr];
      rd_cnt   <= rd_cnt + 1;
    end
  end

  // Handshake monitor: pop expected beat and compare
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      mon_got = {out_opcode, out_operand, out_first, out_iter};
      hs_t.push_back(cyc);
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL beat_unexpected got %h required none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          mismatched++;
          $display("FAIL beat got %h required %h", mon_got, mon_exp);
        end
      end
    end
  end

  function automatic logic [31:0] w(input logic [3:0] op,
                                    input logic [27:0] v);
    return {op, v};
  endfunction

  function automatic logic [48:0] beat(input logic [3:0] op,
                                       input logic [27:0] v,
                                       input logic f,
                                       input logic [15:0] it);
    return {op, v, f, it};
  endfunction

  function automatic logic [61:0] outs();
    return {mem_rd_en, mem_addr, out_valid, out_opcode, out_operand,
            out_first, out_iter, busy, done, error};
  endfunction

  function automatic logic [49:0] beat_outs();
    return {out_valid, out_opcode, out_operand, out_first, out_iter};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic pulse_start(input logic [7:0] a);
    @(posedge clk); #1;
    start_addr = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 300; i++) begin
      if (done || error) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    compared++;
    if (outs() !== '0) begin
      mismatched++;
      $display("FAIL reset_outs got %h required 0", outs());
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (outs() !== '0) begin
      mismatched++;
      $display("FAIL idle_outs got %h required 0", outs());
    end
  endtask

  task automatic test_single();
    clear_mem();
    mem[0] = w(4'h1, 28'h10);
    mem[1] = w(4'h0, 28'h0);
    sb.push_back(beat(4'h1, 28'h10, 1'b1, 16'd0));
    pulse_start(8'h00);
    compared++;
    if ({mem_rd_en, mem_addr, busy} !== {1'b1, 8'h00, 1'b1}) begin
      mismatched++;
      $display("FAIL req_cycle got %b/%h/%b required 1/00/1",
               mem_rd_en, mem_addr, busy);
    end
    @(posedge clk); #1;
    compared++;
    if ({mem_rd_en, out_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL latch_cycle got %b%b required 00", mem_rd_en, out_valid);
    end
    @(posedge clk); #1;
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL first_valid_t3 got %b required 1", out_valid);
    end
    wait_end();
    @(posedge clk); #1;
    compared++;
    if ({done, busy, error} !== 3'b100) begin
      mismatched++;
      $display("FAIL single_end got %b required 100", {done, busy, error});
    end
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("FAIL single_left got %0d required 0", sb.size());
    end
  endtask

  task automatic test_repeat();
    clear_mem();
    mem[0] = w(4'h2, 28'h55);
    mem[1] = w(4'hF, 28'd3);
    mem[2] = w(4'hF, 28'd0);
    mem[3] = w(4'hF, 28'd1);
    mem[4] = w(4'h0, 28'h0);
    sb.push_back(beat(4'h2, 28'h55, 1'b1, 16'd0));
    for (int k = 1; k <= 3; k++)
      sb.push_back(beat(4'h2, 28'h55, 1'b0, 16'(k)));
    sb.push_back(beat(4'h2, 28'h55, 1'b0, 16'd1));
    pulse_start(8'h00);
    wait_end();
    compared++;
    if ({done, error, busy} !== 3'b100) begin
      mismatched++;
      $display("FAIL repeat_end got %b required 100", {done, error, busy});
    end
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("FAIL repeat_left got %0d required 0", sb.size());
    end
  endtask

  task automatic test_bad_repeat();
    clear_mem();
    mem[0]    = w(4'hF, 28'd2);
    mem[8'h10] = w(4'h0, 28'h0);
    pulse_start(8'h00);
    wait_end();
    @(posedge clk); #1;
    compared++;
    if ({error, done, busy, out_valid} !== 4'b1000) begin
      mismatched++;
      $display("FAIL bad_rep got %b required 1000",
               {error, done, busy, out_valid});
    end
    pulse_start(8'h10);
    compared++;
    if (error !== 1'b0) begin
      mismatched++;
      $display("FAIL error_clear got %b required 0", error);
    end
    wait_end();
    compared++;
    if ({done, error} !== 2'b10) begin
      mismatched++;
      $display("FAIL restart_end got %b required 10", {done, error});
    end
  endtask

  task automatic test_stall();
    logic [49:0] snap;
    bit          have;
    int          stalls;
    clear_mem();
    mem[0] = w(4'h5, 28'h123);
    mem[1] = w(4'hF, 28'd2);
    mem[2] = w(4'h0, 28'h0);
    sb.push_back(beat(4'h5, 28'h123, 1'b1, 16'd0));
    sb.push_back(beat(4'h5, 28'h123, 1'b0, 16'd1));
    sb.push_back(beat(4'h5, 28'h123, 1'b0, 16'd2));
    have   = 1'b0;
    stalls = 0;
    snap   = '0;
    pulse_start(8'h00);
    for (int k = 0; k < 16; k++) begin
      if (out_valid && out_iter == 16'd2 && stalls < 2) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      if (have) begin
        compared++;
        if (beat_outs() !== snap) begin
          mismatched++;
          $display("FAIL stall_hold got %h required %h", beat_outs(), snap);
        end
      end
      have = out_valid && !out_ready;
      snap = beat_outs();
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_end();
    compared++;
    if (stalls !== 2) begin
      mismatched++;
      $display("FAIL stall_seen got %0d required 2", stalls);
    end
    compared++;
    if ({done, sb.size() == 0} !== 2'b11) begin
      mismatched++;
      $display("FAIL stall_end got done=%b left=%0d required 1/0",
               done, sb.size());
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[8'hFF] = w(4'h3, 28'hABC);
    mem[8'h00] = w(4'h0, 28'h0);
    sb.push_back(beat(4'h3, 28'hABC, 1'b1, 16'd0));
    pulse_start(8'hFF);
    wait_end();
    compared++;
    if ({done, error, sb.size() == 0} !== 3'b101) begin
      mismatched++;
      $display("FAIL wrap_end got done=%b err=%b left=%0d required 1/0/0",
               done, error, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int  r;
    bit  hit;
    clear_mem();
    mem[8'h20] = w(4'h4, 28'h777);
    mem[8'h21] = w(4'hF, 28'd5);
    sb.push_back(beat(4'h4, 28'h777, 1'b1, 16'd0));
    for (int k = 1; k <= 5; k++)
      sb.push_back(beat(4'h4, 28'h777, 1'b0, 16'(k)));
    hit = 1'b0;
    pulse_start(8'h20);
    for (int i = 0; i < 30; i++) begin
      if (out_valid && out_iter == 16'd2) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    compared++;
    if (hit !== 1'b1) begin
      mismatched++;
      $display("FAIL replay_reach got %b required 1", hit);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (outs() !== '0) begin
      mismatched++;
      $display("FAIL async_reset got %h required 0", outs());
    end
    r = rd_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (rd_cnt !== r) begin
      mismatched++;
      $display("FAIL reads_after_reset got %0d required %0d", rd_cnt, r);
    end
    compared++;
    if (outs() !== '0) begin
      mismatched++;
      $display("FAIL post_reset got %h required 0", outs());
    end
  endtask

  task automatic test_throughput();
    clear_mem();
    for (int i = 0; i < 5; i++) begin
      mem[i] = w(4'(i + 1), 28'(i * 17));
      sb.push_back(beat(4'(i + 1), 28'(i * 17), 1'b1, 16'd0));
    end
    mem[5] = w(4'h0, 28'h0);
    hs_t.delete();
    pulse_start(8'h00);
    wait_end();
    compared++;
    if (hs_t.size() !== 5) begin
      mismatched++;
      $display("FAIL tput_beats got %0d required 5", hs_t.size());
    end else begin
      compared++;
      if (hs_t[4] - hs_t[0] !== SPAN) begin
        mismatched++;
        $display("FAIL tput_span got %0d required %0d",
                 hs_t[4] - hs_t[0], SPAN);
      end
    end
    compared++;
    if ({done, sb.size() == 0} !== 2'b11) begin
      mismatched++;
      $display("FAIL tput_end got done=%b left=%0d required 1/0",
               done, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_bad_repeat();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_throughput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
